// File: rtl/eros_pkg.sv
// System-level constants; the REG2OBI_* values configure the reg-to-OBI bridge instance.
package eros_pkg;

  localparam logic [31:0] REG2OBI_ADDR_FIRST     = 32'h1000_0000;
  localparam logic [31:0] REG2OBI_ADDR_LAST      = 32'h2000_FFFF;
  localparam int unsigned REG2OBI_TIMEOUT_CYCLES = 32'd1024;

endpackage

// File: rtl/obi_pkg.sv
// OBI master-side request and slave-side response types.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by register-bus agents and bridges.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge.sv
// Register-bus to OBI initiator bridge. One transaction in flight; an address
// window filters requests and a response timeout keeps a dead slave from
// hanging the register bus. A timed-out response is later swallowed in DRAIN.
module reg_to_obi_bridge
  import reg_pkg::*;
  import obi_pkg::*;
#(
  parameter logic [31:0] AddrFirst     = 32'h0000_0000,
  parameter logic [31:0] AddrLast      = 32'hFFFF_FFFF,
  parameter int unsigned TimeoutCycles = 32'd1024
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  master_req_o,
  input  obi_resp_t master_resp_i
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_RSP    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } hold_t;

  localparam bit          TimeoutEn = (TimeoutCycles != 32'd0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 32'd1) : 32'd1;
  localparam logic [CntW-1:0] CntLast =
    CntW'(TimeoutEn ? (TimeoutCycles - 32'd1) : 32'd0);

  state_e          state_q, state_d;
  hold_t           hold_q,  hold_d;
  logic            req_q,   req_d;
  reg_rsp_t        rsp_q,   rsp_d;
  logic [CntW-1:0] cnt_q,   cnt_d;
  logic            drain_q, drain_d;

  // Unsigned inclusive window compare on the incoming address.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= AddrFirst) && (addr <= AddrLast);
  endfunction

  // Next-state and registered-output computation for the bridge FSM.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        rsp_d.ready = 1'b0;
        if (reg_req_i.valid) begin
          hold_d.write = reg_req_i.write;
          hold_d.addr  = reg_req_i.addr;
          hold_d.wdata = reg_req_i.wdata;
          hold_d.wstrb = reg_req_i.wstrb;
          if (in_window(reg_req_i.addr)) begin
            req_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            rsp_d.ready = 1'b1;
            rsp_d.rdata = 32'h0000_0000;
            rsp_d.error = 1'b1;
            state_d     = ST_RSP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // req stays up until granted; OBI does not allow withdrawing it.
        if (master_resp_i.gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_R;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        // rvalid has priority over a simultaneous timeout expiry.
        if (master_resp_i.rvalid) begin
          rsp_d.ready = 1'b1;
          rsp_d.rdata = hold_q.write ? 32'h0000_0000 : master_resp_i.rdata;
          rsp_d.error = 1'b0;
          state_d     = ST_RSP;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          rsp_d.ready = 1'b1;
          rsp_d.rdata = 32'h0000_0000;
          rsp_d.error = 1'b1;
          drain_d     = 1'b1;
          state_d     = ST_RSP;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1'b1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RSP: begin
        rsp_d.ready = 1'b0;
        if (drain_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The orphaned response is dropped; its data never reaches rdata.
        if (master_resp_i.rvalid) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        rsp_d   = '0;
        cnt_d   = '0;
        drain_d = 1'b0;
      end
    endcase
  end

  // State, holding and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      req_q   <= 1'b0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // OBI request fields come straight from registers.
  always_comb begin
    master_req_o.req   = req_q;
    master_req_o.we    = hold_q.write;
    master_req_o.be    = hold_q.wstrb;
    master_req_o.addr  = hold_q.addr;
    master_req_o.wdata = hold_q.wdata;
  end

  assign reg_rsp_o = rsp_q;

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Scoreboard bench for reg_to_obi_bridge: a transaction-level model predicts
// each register response (data, error, cycle) and each OBI request; a
// behavioural OBI slave and a response monitor check the DUT against them.
module tb_reg_to_obi_bridge;
  import reg_pkg::*;
  import obi_pkg::*;

  localparam logic [31:0] WIN_FIRST = 32'h1000_0000;
  localparam logic [31:0] WIN_LAST  = 32'h2000_FFFF;
  localparam int          TMO       = 8;
  localparam logic [31:0] LATE_DATA = 32'hBADD_A7A0;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gd;       // grant stall cycles
    int          rd;       // cycles after the grant-following cycle until rvalid
    logic [31:0] sdata;    // slave read data
    int          req_cyc;  // cycle in which req must first be seen
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    int          cyc;
  } exp_rsp_t;

  logic      clk;
  logic      rst_ni;
  reg_req_t  rq;
  reg_rsp_t  rsp;
  obi_req_t  mreq;
  obi_resp_t sresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_at = 0;
  int exp_grants = 0;
  int sl_grants = 0;

  txn_t     obi_q[$];
  exp_rsp_t rsp_q[$];

  reg_to_obi_bridge #(
    .AddrFirst    (WIN_FIRST),
    .AddrLast     (WIN_LAST),
    .TimeoutCycles(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .reg_req_i    (rq),
    .reg_rsp_o    (rsp),
    .master_req_o (mreq),
    .master_resp_i(sresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input int gd, input int rd,
                              input logic [31:0] sd);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = wd; t.wstrb = s;
    t.gd = gd; t.rd = rd; t.sdata = sd; t.req_cyc = 0;
    return t;
  endfunction

  // Model the transaction, drive it, and hold valid until ready is seen.
  task automatic issue(input txn_t t_in);
    txn_t t;
    exp_rsp_t e;
    int a;
    bit got;
    t = t_in;
    a = (cyc > free_at) ? cyc : free_at;
    t.req_cyc = a + 1;
    if (t.addr < WIN_FIRST || t.addr > WIN_LAST) begin
      e.rdata = 32'h0; e.error = 1'b1; e.cyc = a + 1;
      free_at = a + 2;
    end else begin
      obi_q.push_back(t);
      exp_grants++;
      if (t.rd < TMO) begin
        e.rdata = t.write ? 32'h0 : t.sdata; e.error = 1'b0;
        e.cyc = a + 3 + t.gd + t.rd;
        free_at = e.cyc + 1;
      end else begin
        e.rdata = 32'h0; e.error = 1'b1;
        e.cyc = a + 2 + t.gd + TMO;
        free_at = a + 2 + t.gd + t.rd + 1;
      end
    end
    rsp_q.push_back(e);
    rq.valid = 1'b1; rq.write = t.write; rq.addr = t.addr;
    rq.wdata = t.wdata; rq.wstrb = t.wstrb;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = rsp.ready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_wait: no ready within 400 cycles for addr %h", t.addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rq.valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Response monitor: every ready pulse pops and checks one expected response.
  initial begin
    exp_rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && rsp.ready) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: rdata %h error %b", rsp.rdata, rsp.error);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp.rdata, e.rdata);
          chk("rsp_error", 32'(rsp.error), 32'(e.error));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Behavioural OBI slave: checks requests against the model and answers them.
  initial begin
    int   ph;
    int   cnt;
    txn_t cur;
    ph = 0; cnt = 0;
    sresp.gnt = 1'b0; sresp.rvalid = 1'b0; sresp.rdata = 32'h0;
    forever begin
      @(negedge clk);
      sresp.gnt = 1'b0; sresp.rvalid = 1'b0;
      if (!rst_ni) begin
        ph = 0;
      end else begin
        case (ph)
          0: begin
            if (obi_q.size() == 0) begin
              chk("stray_req", 32'(mreq.req), 32'h0);
              if (!mreq.req && $urandom_range(0, 7) == 0) begin
                sresp.rvalid = 1'b1;
                sresp.rdata  = $urandom;
              end
            end else if (mreq.req) begin
              cur = obi_q.pop_front();
              chk("req_cycle", 32'(cyc), 32'(cur.req_cyc));
              chk("req_we", 32'(mreq.we), 32'(cur.write));
              chk("req_be", 32'(mreq.be), 32'(cur.wstrb));
              chk("req_addr", mreq.addr, cur.addr);
              chk("req_wdata", mreq.wdata, cur.wdata);
              if (cur.gd == 0) begin
                sresp.gnt = 1'b1; sl_grants++; cnt = 0; ph = 2;
              end else begin
                cnt = 1; ph = 1;
              end
            end
          end
          1: begin
            chk("req_held", 32'(mreq.req), 32'h1);
            chk("held_addr", mreq.addr, cur.addr);
            chk("held_wdata", mreq.wdata, cur.wdata);
            chk("held_be_we", {27'h0, mreq.we, mreq.be}, {27'h0, cur.write, cur.wstrb});
            if (cnt == cur.gd) begin
              sresp.gnt = 1'b1; sl_grants++; cnt = 0; ph = 2;
            end else begin
              cnt++;
            end
          end
          2: begin
            chk("req_after_gnt", 32'(mreq.req), 32'h0);
            if (cnt == cur.rd) begin
              sresp.rvalid = 1'b1;
              sresp.rdata  = (cur.rd < TMO) ? cur.sdata : LATE_DATA;
              ph = 0;
            end else begin
              cnt++;
            end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    rst_ni = 1'b0;
    rq = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rsp.ready), 32'h0);
    chk("rst_rdata", rsp.rdata, 32'h0);
    chk("rst_error", 32'(rsp.error), 32'h0);
    chk("rst_req", 32'(mreq.req), 32'h0);
    chk("rst_req_fields", mreq.addr | mreq.wdata | {27'h0, mreq.we, mreq.be}, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    free_at = cyc;

    // Zero-wait read.
    issue(mk(1'b0, 32'h1000_0010, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF));
    idle(2);
    // Write with grant withheld four cycles.
    issue(mk(1'b1, 32'h1000_0020, 32'hCAFE_0001, 4'h3, 4, 0, 32'h5555_AAAA));
    idle(1);
    // Out-of-window accesses, including just outside both edges.
    issue(mk(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 32'h1111_1111));
    issue(mk(1'b0, 32'h0FFF_FFFF, 32'h0, 4'hF, 0, 0, 32'h2222_2222));
    issue(mk(1'b1, 32'h2001_0000, 32'h77, 4'h1, 0, 0, 32'h3333_3333));
    // Window edges are inclusive.
    issue(mk(1'b0, 32'h1000_0000, 32'h0, 4'hF, 1, 2, 32'h0A0B_0C0D));
    issue(mk(1'b0, 32'h2000_FFFF, 32'h0, 4'hF, 0, 1, 32'h1234_0FFF));
    // rvalid on the expiry cycle wins.
    issue(mk(1'b0, 32'h1800_0000, 32'h0, 4'hF, 0, TMO - 1, 32'hFACE_0007));
    idle(2);
    // Timeout, then a held read waits through the drain of the late response.
    issue(mk(1'b0, 32'h1000_0040, 32'h0, 4'hF, 0, TMO + 3, 32'h0));
    issue(mk(1'b0, 32'h1000_0100, 32'h0, 4'hF, 0, 0, 32'h1234_5678));
    idle(1);
    // Three back-to-back reads.
    issue(mk(1'b0, 32'h1000_0200, 32'h0, 4'hF, 0, 0, 32'hA1A1_0001));
    issue(mk(1'b0, 32'h1000_0204, 32'h0, 4'hF, 0, 0, 32'hB2B2_0002));
    issue(mk(1'b0, 32'h1000_0208, 32'h0, 4'hF, 0, 0, 32'hC3C3_0003));
    idle(3);

    // Reset while the request is stalled in REQ.
    t = mk(1'b0, 32'h1000_0300, 32'h0, 4'hF, 50, 0, 32'h0);
    t.req_cyc = ((cyc > free_at) ? cyc : free_at) + 1;
    obi_q.push_back(t);
    rq.valid = 1'b1; rq.write = t.write; rq.addr = t.addr;
    rq.wdata = t.wdata; rq.wstrb = t.wstrb;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_req", 32'(mreq.req), 32'h1);
    rst_ni = 1'b0;
    rq.valid = 1'b0;
    #1;
    chk("async_rst_req", 32'(mreq.req), 32'h0);
    chk("async_rst_ready", 32'(rsp.ready), 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    obi_q.delete();
    rsp_q.delete();
    rst_ni = 1'b1;
    free_at = cyc;
    issue(mk(1'b0, 32'h1000_0400, 32'h0, 4'hF, 0, 0, 32'h600D_DA7A));

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int rd;
      if ($urandom_range(0, 9) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h0FFF_FFFF))
                                        : 32'h3000_0000 + 32'($urandom_range(0, 255));
      end else begin
        a = WIN_FIRST + ($urandom % 32'h1001_0000);
      end
      rd = ($urandom_range(0, 9) == 0) ? TMO + 1 + $urandom_range(0, 3)
                                      : $urandom_range(0, TMO - 1);
      issue(mk(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), rd, $urandom));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    idle(20);

    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
    chk("obi_queue_empty", 32'(obi_q.size()), 32'h0);
    // The aborted request in the reset test was never granted.
    chk("grant_count", 32'(sl_grants), 32'(exp_grants));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
